dct_seq_dma: RTL and testbench

- Autonomous sequencer that offloads one DCT job from the CPU.
- Accepts a job command (source base, destination base, log2 size, Q-format M).
- Programs the avalon_dct peripheral through its Avalon slave port: SETQ, then START, then size DATA writes. It then reads back every coefficient, honouring the peripheral's done stall, and writes the results to memory.
- Sits between the CPU command register block, the shared data memory port and the DCT slave.

---
 rtl/dct_seq_dma_pkg.sv | 29 ++
 rtl/dct_seq_dma_if.sv | 31 +++
 rtl/dct_seq_dma.sv | 176 +++++++++++++++++
 tb/tb_dct_seq_dma.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_seq_dma_pkg.sv
// rtl/dct_seq_dma_pkg.sv - shared types and DCT register map for the DCT job sequencer
package dct_seq_pkg;

    localparam int SEQ_ADDR_W = 16;
    localparam int SEQ_NBITS  = 16;

    localparam logic [7:0] DCT_ADDR_START = 8'd0;
    localparam logic [7:0] DCT_ADDR_DATA  = 8'd1;
    localparam logic [7:0] DCT_ADDR_SETQ  = 8'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETQ,
        ST_START,
        ST_FETCH,
        ST_PUSH,
        ST_RDBACK,
        ST_STORE,
        ST_FIN
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_ADDR_W-1:0] src;
        logic [SEQ_ADDR_W-1:0] dst;
        logic [2:0]            log2n;
        logic [SEQ_NBITS-1:0]  m;
    } seq_job_t;

endpackage

// File: rtl/dct_seq_dma_if.sv
// rtl/dct_seq_dma_if.sv - data memory port and DCT Avalon slave port seen by the sequencer
interface dct_seq_dma_if #(
    parameter int NBITS  = 16,
    parameter int ADDR_W = 16
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [NBITS-1:0]  mem_rdata;
    logic              mem_write;
    logic [NBITS-1:0]  mem_wdata;
    logic [7:0]        dct_address;
    logic              dct_read;
    logic              dct_write;
    logic [NBITS-1:0]  dct_writedata;
    logic [NBITS-1:0]  dct_readdata;
    logic              dct_done;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        output dct_address, dct_read, dct_write, dct_writedata,
        input  mem_rdata, dct_readdata, dct_done
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        input  dct_address, dct_read, dct_write, dct_writedata,
        output mem_rdata, dct_readdata, dct_done
    );

endinterface

// File: rtl/dct_seq_dma.sv
// rtl/dct_seq_dma.sv - one-job DCT sequencer: load samples, read coefficients, store results
// Optional readback stall watchdog enabled by defining DCT_SEQ_TIMEOUT_EN.
module dct_seq_dma
    import dct_seq_pkg::*;
#(
    parameter int MAX_SIZE       = 64,
    parameter int LOG2_MAX       = $clog2(MAX_SIZE),
    parameter int NBITS          = SEQ_NBITS,
    parameter int ADDR_W         = SEQ_ADDR_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [2:0]        cmd_log2n,
    input  logic [NBITS-1:0]  cmd_m,
    output logic              busy,
    output logic              job_done,
    output logic              job_err,
    dct_seq_dma_if.master     bus
);

    localparam int KW = LOG2_MAX;

    // The job register is packed at package widths, so the ports must agree.
    if (NBITS != SEQ_NBITS || ADDR_W != SEQ_ADDR_W) begin : g_bad_width
        $error("dct_seq_dma: NBITS/ADDR_W differ from dct_seq_pkg job widths");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("dct_seq_dma: TIMEOUT_CYCLES must be at least 2");
    end

    seq_state_t       state_q, state_d;
    seq_job_t         job_q;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    n_m1_q;
    logic [NBITS-1:0] hold_q;
    logic             err_q;
    logic             accept;
    logic             bad_size;
    logic             last;

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_FIN);
    assign busy      = !cmd_ready;
    assign job_done  = (state_q == ST_FIN);
    assign job_err   = err_q;
    assign accept    = cmd_valid && cmd_ready;
    assign bad_size  = (cmd_log2n == 3'd0) || (int'(cmd_log2n) > LOG2_MAX);
    assign last      = (k_q == n_m1_q);

`ifdef DCT_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES);
    logic [SW-1:0] stall_q;
    logic          timeout;

    assign timeout = (state_q == ST_RDBACK) && !bus.dct_done
                     && (stall_q == SW'(TIMEOUT_CYCLES - 1));

    // Held at zero outside RDBACK, so each coefficient starts a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == ST_RDBACK && !bus.dct_done) begin
            stall_q <= stall_q + 1'b1;
        end else begin
            stall_q <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        bus.mem_addr      = '0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_wdata     = '0;
        bus.dct_address   = '0;
        bus.dct_read      = 1'b0;
        bus.dct_write     = 1'b0;
        bus.dct_writedata = '0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = (accept && !bad_size) ? ST_SETQ : ST_IDLE;
            end
            ST_SETQ: begin
                bus.dct_write     = 1'b1;
                bus.dct_address   = DCT_ADDR_SETQ;
                bus.dct_writedata = job_q.m;
                state_d           = ST_START;
            end
            ST_START: begin
                bus.dct_write     = 1'b1;
                bus.dct_address   = DCT_ADDR_START;
                bus.dct_writedata = NBITS'(job_q.log2n);
                state_d           = ST_FETCH;
            end
            ST_FETCH: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = job_q.src + ADDR_W'(k_q);
                state_d      = ST_PUSH;
            end
            ST_PUSH: begin
                bus.dct_write     = 1'b1;
                bus.dct_address   = DCT_ADDR_DATA;
                bus.dct_writedata = bus.mem_rdata;
                state_d           = last ? ST_RDBACK : ST_FETCH;
            end
            ST_RDBACK: begin
                bus.dct_read    = 1'b1;
                bus.dct_address = 8'(k_q);
                if (bus.dct_done) begin
                    state_d = ST_STORE;
                end
`ifdef DCT_SEQ_TIMEOUT_EN
                else if (timeout) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_STORE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = job_q.dst + ADDR_W'(k_q);
                bus.mem_wdata = hold_q;
                state_d       = last ? ST_FIN : ST_RDBACK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job_q  <= '0;
            k_q    <= '0;
            n_m1_q <= '0;
            hold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (accept) begin
                        job_q  <= '{src: cmd_src, dst: cmd_dst, log2n: cmd_log2n, m: cmd_m};
                        n_m1_q <= KW'((32'd1 << cmd_log2n) - 32'd1);
                        k_q    <= '0;
                        err_q  <= bad_size;
                    end
                end
                ST_PUSH: k_q <= last ? '0 : k_q + 1'b1;
                ST_RDBACK: begin
                    if (bus.dct_done) begin
                        hold_q <= bus.dct_readdata;
                    end
`ifdef DCT_SEQ_TIMEOUT_EN
                    else if (timeout) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                ST_STORE: k_q <= k_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_seq_dma.sv
// tb/tb_dct_seq_dma.sv - randomized self-checking bench for dct_seq_dma with memory and DCT models
module tb_dct_seq_dma;

    localparam int TMO = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_src = '0;
    logic [15:0] cmd_dst = '0;
    logic [2:0]  cmd_log2n = '0;
    logic [15:0] cmd_m = '0;
    logic        busy, job_done, job_err;

    always #5 clk = ~clk;

    dct_seq_dma_if #(.NBITS(16), .ADDR_W(16)) bus ();

    dct_seq_dma #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_log2n (cmd_log2n),
        .cmd_m     (cmd_m),
        .busy      (busy),
        .job_done  (job_done),
        .job_err   (job_err),
        .bus       (bus)
    );

    // Memory: reads answer one cycle later from src_img; writes only go to the log.
    logic [15:0] src_img [0:65535];
    logic [15:0] rdata_q = '0;
    assign bus.mem_rdata = rdata_q;
    always @(posedge clk) begin
        if (bus.mem_read) rdata_q <= src_img[bus.mem_addr];
    end

    // DCT stand-in: coefficient k = sample[k] ^ (M + k*0x0101 + log2n), stalled stall_n cycles.
    logic [15:0] dq = '0, dl2 = '0;
    logic [15:0] dsamp [0:63];
    logic [5:0]  dcnt = '0;
    int          stall_cnt = 0;
    int          stall_n = 0;
    bit          hold_en = 1'b0;
    int          hold_k = 0;
    always @(posedge clk) begin
        if (bus.dct_write) begin
            case (bus.dct_address)
                8'd2: dq <= bus.dct_writedata;
                8'd0: begin dl2 <= bus.dct_writedata; dcnt <= '0; end
                8'd1: begin dsamp[dcnt] <= bus.dct_writedata; dcnt <= dcnt + 6'd1; end
                default: ;
            endcase
        end
        if (bus.dct_read && !bus.dct_done) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end
    assign bus.dct_done = !(hold_en && bus.dct_address == 8'(hold_k)) && (stall_cnt >= stall_n);
    assign bus.dct_readdata = dsamp[bus.dct_address[5:0]]
                              ^ (dq + {bus.dct_address, bus.dct_address} + dl2);

    acc_t        mw_q[$], dw_q[$];
    logic [15:0] mr_q[$];
    int n_done = 0, n_err = 0, n_busy = 0, n_viol = 0, n_dread = 0, n_rd2 = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_read) mr_q.push_back(bus.mem_addr);
            if (bus.mem_write) mw_q.push_back('{bus.mem_addr, bus.mem_wdata});
            if (bus.dct_write) dw_q.push_back('{{8'h00, bus.dct_address}, bus.dct_writedata});
            n_done  <= n_done + int'(job_done);
            n_err   <= n_err + int'(job_err);
            n_busy  <= n_busy + int'(busy);
            n_dread <= n_dread + int'(bus.dct_read);
            n_rd2   <= n_rd2 + int'(bus.dct_read && bus.dct_address == 8'd2);
            if ($countones({bus.mem_read, bus.mem_write, bus.dct_read, bus.dct_write}) > 1)
                n_viol <= n_viol + 1;
        end
    end

    int n_checks = 0, n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] coef(input logic [15:0] a, input int k,
                                          input logic [15:0] m, input logic [2:0] l2);
        return src_img[a] ^ (m + 16'(k) * 16'h0101 + 16'(l2));
    endfunction

    task automatic run_job(input logic [15:0] src, input logic [15:0] dst, input logic [2:0] l2,
                           input logic [15:0] m, input int stall, input bit inject);
        int n = 1 << l2;
        int cyc;
        int mr0 = mr_q.size(), mw0 = mw_q.size(), dw0 = dw_q.size();
        int d0 = n_done, e0 = n_err;
        logic [15:0] a;
        stall_n = stall;
        @(negedge clk);
        check("ready_before_job", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_log2n = l2; cmd_m = m;
        @(posedge clk); #1 cmd_valid = 1'b0;
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 6) begin
                cmd_valid = 1'b1; cmd_src = ~src; cmd_dst = ~dst; cmd_log2n = 3'd1;
            end
            if (inject && cyc == 9) cmd_valid = 1'b0;
        end while (!job_done && cyc < 4 * n + 4 + n * stall + 50);
        check("job_done_seen", job_done, 1);
        check("latency", cyc, 4 * n + 4 + n * stall);
        check("ready_at_done", cmd_ready, 1);
        check("busy_at_done", busy, 0);
        @(negedge clk); #1;
        check("fetch_count", mr_q.size() - mr0, n);
        check("dct_write_count", dw_q.size() - dw0, n + 2);
        check("store_count", mw_q.size() - mw0, n);
        if (dw_q.size() - dw0 == n + 2) begin
            check("setq_write", dw_q[dw0], {16'd2, m});
            check("start_write", dw_q[dw0 + 1], {16'd0, 13'd0, l2});
        end
        for (int k = 0; k < n; k++) begin
            a = src + 16'(k);
            if (mr0 + k < mr_q.size()) check("fetch_addr", mr_q[mr0 + k], a);
            if (dw0 + 2 + k < dw_q.size()) check("data_write", dw_q[dw0 + 2 + k], {16'd1, src_img[a]});
            if (mw0 + k < mw_q.size()) check("store", mw_q[mw0 + k], {dst + 16'(k), coef(a, k, m, l2)});
        end
        check("done_pulses", n_done - d0, 1);
        check("err_pulses", n_err - e0, 0);
    endtask

    task automatic run_bad(input logic [2:0] l2);
        int e0 = n_err, b0 = n_busy, d0 = n_dread;
        int act0 = mr_q.size() + mw_q.size() + dw_q.size();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 16'h0123; cmd_dst = 16'h0456; cmd_log2n = l2; cmd_m = 16'h0001;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("bad_err_pulse", n_err - e0, 1);
        check("bad_busy", n_busy - b0, 0);
        check("bad_bus_activity", mr_q.size() + mw_q.size() + dw_q.size() - act0 + n_dread - d0, 0);
        check("bad_ready", cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushes, cyc, d0, e0, mw0, r0;
        logic [15:0] src, dst;
        logic [2:0]  l2;
        for (int i = 0; i < 65536; i++) src_img[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) dsamp[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_flags", {busy, job_done, job_err}, 0);
        check("rst_strobes", {bus.mem_read, bus.mem_write, bus.dct_read, bus.dct_write}, 0);
        check("rst_addr", {bus.mem_addr, 8'h00, bus.dct_address}, 0);
        check("rst_data", {bus.mem_wdata, bus.dct_writedata}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) src_img[16'h0100 + k] = 16'h4000;
        run_job(16'h0100, 16'h0200, 3'd3, 16'h0000, 3, 1'b0);

        run_bad(3'd7);
        run_bad(3'd0);

        run_job(16'h0300, 16'h0400, 3'd3, 16'h1234, 1, 1'b1);

        // Abort on the 5th PUSH cycle, then a short job must still run cleanly.
        d0 = n_done; e0 = n_err; stall_n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 16'h0500; cmd_dst = 16'h0600; cmd_log2n = 3'd3; cmd_m = 16'h0007;
        @(posedge clk); #1 cmd_valid = 1'b0;
        pushes = 0; cyc = 0;
        while (pushes < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.dct_write && bus.dct_address == 8'd1) pushes++;
        end
        check("push5_reached", pushes, 5);
        reset = 1'b1;
        #1;
        check("abort_strobes", {bus.mem_read, bus.mem_write, bus.dct_read, bus.dct_write}, 0);
        check("abort_state", {cmd_ready, busy}, 2'b10);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("abort_no_done", n_done - d0, 0);
        check("abort_no_err", n_err - e0, 0);
        run_job(16'h0700, 16'h0800, 3'd1, 16'h0003, 0, 1'b0);

        run_job(16'hFFFE, 16'h3000, 3'd2, 16'h0021, 0, 1'b0);

`ifdef DCT_SEQ_TIMEOUT_EN
        hold_en = 1'b1; hold_k = 2; stall_n = 0;
        d0 = n_done; e0 = n_err; mw0 = mw_q.size(); r0 = n_rd2;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 16'h0900; cmd_dst = 16'h0A00; cmd_log2n = 3'd3; cmd_m = 16'h0005;
        @(posedge clk); #1 cmd_valid = 1'b0;
        cyc = 0;
        while (!job_err && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_err_seen", job_err, 1);
        check("tmo_busy", busy, 0);
        @(negedge clk); #1;
        hold_en = 1'b0;
        check("tmo_stall_cycles", n_rd2 - r0, TMO);
        check("tmo_stores", mw_q.size() - mw0, 2);
        for (int k = 0; k < 2; k++) begin
            if (mw0 + k < mw_q.size())
                check("tmo_store", mw_q[mw0 + k],
                      {16'h0A00 + 16'(k), coef(16'h0900 + 16'(k), k, 16'h0005, 3'd3)});
        end
        check("tmo_no_done", n_done - d0, 0);
        check("tmo_err_pulses", n_err - e0, 1);
`endif

        repeat (6) begin
            l2  = 3'($urandom_range(1, 6));
            src = 16'($urandom);
            dst = src + 16'h1000 + 16'($urandom_range(0, 16'h7000));
            run_job(src, dst, l2, 16'($urandom), $urandom_range(0, 3), 1'b0);
        end

        check("strobe_exclusive", n_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
